uart_node: RTL and testbench
============================

// Module: uart_node
// PURPOSE
// Full-duplex 8N1/8N2 UART endpoint: serialises a byte onto tx1 on request and
// deserialises frames arriving on rx1. Two instances are cross-wired
// (tx of one -> rx of the other) to form a loopback link driven by a stimulus block.
// One clock (clk_sis); clk_uart is NOT a clock but a slow strobe sampled in clk_sis.
// PARAMETERS
// OSR        16   clk_uart rising edges (ticks) per bit period; min 4
// DATA_W     8    data bits per frame, LSB first
// PORTS
// clk_sis    in   1       system clock, all logic on rising edge
// rst        in   1       asynchronous, active-low reset
// clk_uart   in   1       baud oversample strobe; 2-FF synced, rising edge = 1 tick
// start_bit  in   1       transmit request; rising edge (in clk_sis) starts a frame
// data_in    in   8       byte to send, captured on the start_bit rising edge
// stop_bit   in   1       captured with data_in: 0 = one stop bit, 1 = two stop bits
// tx1        out  1       serial out, idle high
// rx1        in   1       serial in, idle high; 2-FF synchronised before use
// tx_busy    out  1       high from capture until last stop bit completes
// rx_data    out  8       last correctly framed received byte
// rx_valid   out  1       one clk_sis pulse when rx_data updates
// rx_ferr    out  1       one clk_sis pulse: stop bit sampled low
// BEHAVIOUR
// - Reset (rst=0, async): tx1=1, tx_busy=0, rx_data=8'h00, rx_valid=0, rx_ferr=0,
//   both FSMs IDLE, tick/bit counters 0, synchronisers preset to 1.
// - TX FSM: IDLE -> START -> DATA -> STOP -> IDLE. Each state lasts OSR ticks
//   per bit. START drives 0; DATA drives data bits LSB first (8 bits); STOP drives 1
//   for 1 or 2 bit periods per latched stop_bit. tx1 changes only on a tick.
// - start_bit rising edge in IDLE: latch data_in/stop_bit, tx_busy=1 next cycle;
//   frame begins at the next tick. Edges while tx_busy=1 are ignored (no queue).
// - start_bit held high does not retrigger; a new low->high edge is required.
// - RX FSM: IDLE -> START -> DATA -> STOP. Falling edge on synced rx1 in IDLE
//   starts tick count; at tick OSR/2 re-check: if 1, glitch -> back to IDLE.
//   Then sample each data bit every OSR ticks (mid-bit), shift LSB first.
// - RX STOP sample: 1 -> rx_data updated, rx_valid pulse; 0 -> rx_data unchanged,
//   rx_ferr pulse; wait for rx1 high before returning to IDLE. Receiver checks
//   only the first stop bit; extra stop bits look like idle line.
// - rx_valid/rx_ferr pulse exactly one clk_sis cycle, same cycle FSM leaves STOP.
// - TX and RX independent: simultaneous send and receive required.
// - No clk_uart edges -> no progress; FSMs hold state indefinitely.
// - Reset mid-frame: tx1 returns to 1 immediately; partial rx frame discarded.
// STRUCTURE
// - Package uart_pkg: state enum {IDLE,START,DATA,STOP}, OSR default, DATA_W.
// - Sub-module uart_rx_core (sync, start detect, sampler, rx FSM); TX FSM,
//   tick edge detector and start_bit edge detector stay in top.
// TESTING
// - Two instances cross-wired, clk_uart = clk_sis/8, OSR=16.
// - Reset then idle: tx1=1, tx_busy=0, rx_valid never pulses.
// - Send 8'hA5, stop_bit=0 -> tx1 shows 0,1,0,1,0,0,1,0,1,1; peer rx_data=8'hA5,
//   one rx_valid pulse; tx_busy low after 10*OSR ticks.
// - Both sides send simultaneously (8'h3C / 8'hC3) -> each receives other's byte.
// - Send 8'h00 with stop_bit=1 -> 11-bit frame; second start_bit edge during
//   busy ignored; next byte 8'hFF after idle received correctly.
// - Force rx1 low through the stop bit -> rx_ferr pulse, rx_data unchanged;
//   0.25-bit low glitch on rx1 -> no valid, no error.
// - Assert rst mid-data-bit -> tx1=1 immediately, peer receives nothing valid.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the uart_node endpoint and its receive core.
package uart_pkg;

  // Both the transmit and receive sequencers walk through the same four phases.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  // Default number of clk_uart ticks per bit period.
  localparam int unsigned OSR_DEF = 16;

  // Data bits per frame, sent and received LSB first.
  localparam int unsigned DATA_W = 8;

endpackage

// File: rtl/uart_node_if.sv
// Byte-level and serial-line signals of one UART endpoint.
// The node takes the slave view; the stimulus block and the link take the master view.
interface uart_node_if;
  import uart_pkg::*;

  logic              start_bit;
  logic [DATA_W-1:0] data_in;
  logic              stop_bit;
  logic              tx1;
  logic              rx1;
  logic              tx_busy;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ferr;

  modport master (
    output start_bit, data_in, stop_bit, rx1,
    input  tx1, tx_busy, rx_data, rx_valid, rx_ferr
  );

  modport slave (
    input  start_bit, data_in, stop_bit, rx1,
    output tx1, tx_busy, rx_data, rx_valid, rx_ferr
  );

endinterface

// File: rtl/uart_rx_core.sv
// Receive half of the UART endpoint: synchronises rx, detects the start edge,
// confirms it at mid start bit, samples each data bit mid-period and checks the stop bit.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int unsigned OSR = OSR_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              tick_i,
  input  logic              rx_i,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  output logic              rx_ferr_o
);

  localparam int unsigned CNT_W = $clog2(OSR);
  localparam int unsigned BIT_W = $clog2(DATA_W);

  // [0],[1] synchroniser stages, [2] previous synchronised value for edge detection.
  logic [2:0]        rx_sync_q;
  logic              rx_s;
  logic              rx_fall;

  uart_state_e       state_q;
  logic [CNT_W-1:0]  tick_q;
  logic [BIT_W-1:0]  bit_q;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              ferr_q;

  assign rx_s    = rx_sync_q[1];
  assign rx_fall = rx_sync_q[2] & ~rx_sync_q[1];

  // Bring the serial line into clk_i and keep one extra stage for edge detection.
  // NOTE: stages preset to 1 (idle line level) so reset release never looks like a start edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rx_sync_q <= '1;
    else         rx_sync_q <= {rx_sync_q[1:0], rx_i};
  end

  // Receive sequencer; a falling edge is only seen after the line has been high again,
  // which also provides the wait-for-idle after a framing error.
  // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rx_fall) begin
            tick_q  <= '0;
            state_q <= START;
          end
        end
        START: begin
          if (tick_i) begin
            if (tick_q == CNT_W'(OSR / 2 - 1)) begin
              tick_q  <= '0;
              bit_q   <= '0;
              // A line back high at mid start bit was a glitch, not a frame.
              state_q <= rx_s ? IDLE : DATA;
            end else begin
              tick_q <= tick_q + CNT_W'(1);
            end
          end
        end
        DATA: begin
          if (tick_i) begin
            if (tick_q == CNT_W'(OSR - 1)) begin
              tick_q  <= '0;
              shift_q <= {rx_s, shift_q[DATA_W-1:1]};
              if (bit_q == BIT_W'(DATA_W - 1)) state_q <= STOP;
              else                             bit_q   <= bit_q + BIT_W'(1);
            end else begin
              tick_q <= tick_q + CNT_W'(1);
            end
          end
        end
        STOP: begin
          if (tick_i) begin
            if (tick_q == CNT_W'(OSR - 1)) begin
              tick_q  <= '0;
              state_q <= IDLE;
              if (rx_s) begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
              end else begin
                ferr_q  <= 1'b1;
              end
            end else begin
              tick_q <= tick_q + CNT_W'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rx_data_o  = data_q;
  assign rx_valid_o = valid_q;
  assign rx_ferr_o  = ferr_q;

endmodule

// File: rtl/uart_node.sv
// Full-duplex 8N1/8N2 UART endpoint: tick and request edge detection plus the
// transmit sequencer live here; the receive path is in uart_rx_core.
module uart_node
  import uart_pkg::*;
#(
  parameter int unsigned OSR = OSR_DEF
) (
  input  logic        clk_sis,
  input  logic        rst,
  input  logic        clk_uart,
  uart_node_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(OSR);
  localparam int unsigned BIT_W = $clog2(DATA_W);

  logic [2:0]        uart_sync_q;
  logic              tick;
  logic              start_prev_q;
  logic              start_rise;

  uart_state_e       tx_state_q;
  logic [CNT_W-1:0]  tx_tick_q;
  logic [BIT_W-1:0]  tx_bit_q;
  logic [DATA_W-1:0] tx_shift_q;
  logic              tx_two_stop_q;
  logic              tx1_q;
  logic              tx_busy_q;
  logic              tx_bit_end;

  // clk_uart is a strobe, not a clock: synchronise it and turn each rising edge into a tick.
  always_ff @(posedge clk_sis or negedge rst) begin
    if (!rst) uart_sync_q <= '1;
    else      uart_sync_q <= {uart_sync_q[1:0], clk_uart};
  end

  assign tick = uart_sync_q[1] & ~uart_sync_q[2];

  // Remember last start_bit level so a request held high cannot retrigger.
  always_ff @(posedge clk_sis or negedge rst) begin
    if (!rst) start_prev_q <= 1'b1;
    else      start_prev_q <= bus.start_bit;
  end

  assign start_rise = bus.start_bit & ~start_prev_q;
  assign tx_bit_end = tick && (tx_tick_q == CNT_W'(OSR - 1));

  // Transmit sequencer: each bit lasts OSR ticks and tx1 only moves on a tick.
  always_ff @(posedge clk_sis or negedge rst) begin
    if (!rst) begin
      tx_state_q    <= IDLE;
      tx_tick_q     <= '0;
      tx_bit_q      <= '0;
      tx_shift_q    <= '0;
      tx_two_stop_q <= 1'b0;
      tx1_q         <= 1'b1;
      tx_busy_q     <= 1'b0;
    end else begin
      if (tick && tx_state_q != IDLE) begin
        tx_tick_q <= tx_bit_end ? '0 : tx_tick_q + CNT_W'(1);
      end
      case (tx_state_q)
        IDLE: begin
          if (start_rise && !tx_busy_q) begin
            // Capture now; the start bit goes out on the following tick.
            tx_shift_q    <= bus.data_in;
            tx_two_stop_q <= bus.stop_bit;
            tx_busy_q     <= 1'b1;
          end else if (tx_busy_q && tick) begin
            tx1_q      <= 1'b0;
            tx_tick_q  <= '0;
            tx_state_q <= START;
          end
        end
        START: begin
          if (tx_bit_end) begin
            tx1_q      <= tx_shift_q[0];
            tx_shift_q <= tx_shift_q >> 1;
            tx_bit_q   <= '0;
            tx_state_q <= DATA;
          end
        end
        DATA: begin
          if (tx_bit_end) begin
            if (tx_bit_q == BIT_W'(DATA_W - 1)) begin
              tx1_q      <= 1'b1;
              tx_bit_q   <= '0;
              tx_state_q <= STOP;
            end else begin
              tx1_q      <= tx_shift_q[0];
              tx_shift_q <= tx_shift_q >> 1;
              tx_bit_q   <= tx_bit_q + BIT_W'(1);
            end
          end
        end
        STOP: begin
          if (tx_bit_end) begin
            // tx_bit_q counts stop periods already sent.
            if (tx_two_stop_q && tx_bit_q == '0) begin
              tx_bit_q <= BIT_W'(1);
            end else begin
              tx_state_q <= IDLE;
              tx_busy_q  <= 1'b0;
            end
          end
        end
        default: tx_state_q <= IDLE;
      endcase
    end
  end

  assign bus.tx1     = tx1_q;
  assign bus.tx_busy = tx_busy_q;

  uart_rx_core #(
    .OSR (OSR)
  ) u_rx_core (
    .clk_i      (clk_sis),
    .rst_ni     (rst),
    .tick_i     (tick),
    .rx_i       (bus.rx1),
    .rx_data_o  (bus.rx_data),
    .rx_valid_o (bus.rx_valid),
    .rx_ferr_o  (bus.rx_ferr)
  );

endmodule

// File: tb/tb_uart_node.sv
// Two cross-wired uart_node instances; node B's rx can be taken over by a bit-banger.
`timescale 1ns/1ps
module tb_uart_node;
  import uart_pkg::*;

  localparam int OSR     = 16;
  localparam int BIT_CYC = OSR * 8;   // clk_uart = clk_sis/8

  logic clk_sis = 1'b0;
  logic rst = 1'b0;
  logic clk_uart_gen = 1'b0;
  logic uart_en = 1'b1;
  logic clk_uart;
  logic bb_en = 1'b0;
  logic bb_val = 1'b1;

  always #5  clk_sis = ~clk_sis;
  always #40 clk_uart_gen = ~clk_uart_gen;
  assign clk_uart = clk_uart_gen & uart_en;

  uart_node_if if_a();
  uart_node_if if_b();

  assign if_a.rx1 = if_b.tx1;
  assign if_b.rx1 = bb_en ? bb_val : if_a.tx1;

  uart_node #(.OSR(OSR)) u_a (.clk_sis(clk_sis), .rst(rst), .clk_uart(clk_uart), .bus(if_a.slave));
  uart_node #(.OSR(OSR)) u_b (.clk_sis(clk_sis), .rst(rst), .clk_uart(clk_uart), .bus(if_b.slave));

  // Pulse counters for the one-cycle strobes.
  int vcnt_a = 0, vcnt_b = 0, fcnt_a = 0, fcnt_b = 0;
  always @(negedge clk_sis) begin
    if (if_a.rx_valid === 1'b1) vcnt_a++;
    if (if_b.rx_valid === 1'b1) vcnt_b++;
    if (if_a.rx_ferr  === 1'b1) fcnt_a++;
    if (if_b.rx_ferr  === 1'b1) fcnt_b++;
  end

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected line levels of a frame, bit 0 first: start, data LSB first, stop bits.
  function automatic logic [10:0] model_frame(input logic [7:0] d);
    logic [10:0] f;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = d[i];
    return f;
  endfunction

  function automatic int model_busy(input logic two);
    return (two ? 11 : 10) * BIT_CYC;
  endfunction

  task automatic launch(input bit a_en, input logic [7:0] a_d, input logic a_two,
                        input bit b_en, input logic [7:0] b_d, input logic b_two);
    @(negedge clk_sis);
    if (a_en) begin if_a.data_in = a_d; if_a.stop_bit = a_two; if_a.start_bit = 1'b1; end
    if (b_en) begin if_b.data_in = b_d; if_b.stop_bit = b_two; if_b.start_bit = 1'b1; end
    @(negedge clk_sis);
    if_a.start_bit = 1'b0;
    if_b.start_bit = 1'b0;
  endtask

  // Watch node A's tx1: sample every mid-bit and time the busy window from the start edge.
  task automatic capture_a(input int nbits, output logic [10:0] bits, output int busy_cyc,
                           output bit seen);
    int t;
    bits = '1; busy_cyc = 0; seen = 1'b0; t = 0;
    while (if_a.tx1 !== 1'b0 && t < 200) begin @(negedge clk_sis); t++; end
    if (if_a.tx1 !== 1'b0) return;
    seen = 1'b1;
    for (int c = 1; c <= 4000; c++) begin
      @(negedge clk_sis);
      if ((c % BIT_CYC) == BIT_CYC / 2 && (c / BIT_CYC) < nbits) bits[c / BIT_CYC] = if_a.tx1;
      if (if_a.tx_busy === 1'b0) begin busy_cyc = c; break; end
    end
  endtask

  // Drive a frame straight onto node B's rx line.
  task automatic bang_frame(input logic [7:0] d, input logic stop_val, input int extra_low);
    bb_val = 1'b1; bb_en = 1'b1;
    @(negedge clk_sis);
    bb_val = 1'b0;
    repeat (BIT_CYC) @(negedge clk_sis);
    for (int i = 0; i < 8; i++) begin
      bb_val = d[i];
      repeat (BIT_CYC) @(negedge clk_sis);
    end
    bb_val = stop_val;
    repeat (BIT_CYC) @(negedge clk_sis);
    if (!stop_val) repeat (extra_low) @(negedge clk_sis);
    bb_val = 1'b1;
    repeat (2 * BIT_CYC) @(negedge clk_sis);
    bb_en = 1'b0;
  endtask

  typedef struct {
    bit         a_send;
    logic [7:0] a_d;
    logic       a_two;
    bit         b_send;
    logic [7:0] b_d;
    logic       b_two;
    bit         retrig;
    logic [7:0] exp_rx_b;
    logic [7:0] exp_rx_a;
    int         exp_busy;
  } vec_t;

  localparam int N_VEC = 5;
  vec_t        vecs [N_VEC];
  logic [10:0] bits;
  int          busy_cyc;
  bit          seen;
  int          va0, vb0, fa0, fb0, stray;
  logic [7:0]  model_last_b;
  logic [7:0]  d;
  logic        two;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    if_a.start_bit = 1'b0; if_a.data_in = '0; if_a.stop_bit = 1'b0;
    if_b.start_bit = 1'b0; if_b.data_in = '0; if_b.stop_bit = 1'b0;

    vecs[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 8'h00, 1280};
    vecs[1] = '{1'b1, 8'h3C, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b0, 8'h3C, 8'hC3, 1280};
    vecs[2] = '{1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 8'hC3, 1408};
    vecs[3] = '{1'b1, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'hFF, 8'hC3, 1280};
    vecs[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h5A, 1'b1, 1'b0, 8'hFF, 8'h5A, 0};

    // Reset values.
    repeat (4) @(negedge clk_sis);
    check("rst_tx1_a", if_a.tx1, 1'b1);
    check("rst_busy_a", if_a.tx_busy, 1'b0);
    check("rst_rx_data_b", if_b.rx_data, 8'h00);
    check("rst_valid_b", if_b.rx_valid, 1'b0);
    check("rst_ferr_b", if_b.rx_ferr, 1'b0);
    rst = 1'b1;

    // Idle line: nothing moves.
    repeat (1000) @(negedge clk_sis);
    check("idle_tx1_a", if_a.tx1, 1'b1);
    check("idle_tx1_b", if_b.tx1, 1'b1);
    check("idle_busy_a", if_a.tx_busy, 1'b0);
    check("idle_valid_cnt", vcnt_a + vcnt_b + fcnt_a + fcnt_b, 0);

    // Directed vector table.
    for (int i = 0; i < N_VEC; i++) begin
      va0 = vcnt_a; vb0 = vcnt_b; fa0 = fcnt_a; fb0 = fcnt_b;
      launch(vecs[i].a_send, vecs[i].a_d, vecs[i].a_two, vecs[i].b_send, vecs[i].b_d, vecs[i].b_two);
      if (vecs[i].a_send) begin
        if (vecs[i].retrig) begin
          fork
            capture_a(vecs[i].a_two ? 11 : 10, bits, busy_cyc, seen);
            begin
              repeat (300) @(negedge clk_sis);
              launch(1'b1, 8'h77, 1'b0, 1'b0, 8'h00, 1'b0);
            end
          join
        end else begin
          capture_a(vecs[i].a_two ? 11 : 10, bits, busy_cyc, seen);
        end
        check($sformatf("row%0d_start_seen", i), seen, 1'b1);
        check($sformatf("row%0d_frame", i), bits, model_frame(vecs[i].a_d));
        check($sformatf("row%0d_busy_cyc", i), busy_cyc, vecs[i].exp_busy);
        stray = 0;
        repeat (300) begin
          @(negedge clk_sis);
          if (if_a.tx1 !== 1'b1 || if_a.tx_busy !== 1'b0) stray++;
        end
        check($sformatf("row%0d_tx_quiet", i), stray, 0);
      end else begin
        repeat (11 * BIT_CYC + 200) @(negedge clk_sis);
      end
      repeat (200) @(negedge clk_sis);
      check($sformatf("row%0d_rx_data_b", i), if_b.rx_data, vecs[i].exp_rx_b);
      check($sformatf("row%0d_rx_data_a", i), if_a.rx_data, vecs[i].exp_rx_a);
      check($sformatf("row%0d_valid_b", i), vcnt_b - vb0, vecs[i].a_send);
      check($sformatf("row%0d_valid_a", i), vcnt_a - va0, vecs[i].b_send);
      check($sformatf("row%0d_ferr", i), (fcnt_a - fa0) + (fcnt_b - fb0), 0);
    end
    model_last_b = 8'hFF;

    // Frozen clk_uart: request captured, but the line does not move.
    uart_en = 1'b0;
    vb0 = vcnt_b;
    launch(1'b1, 8'h96, 1'b0, 1'b0, 8'h00, 1'b0);
    @(negedge clk_sis);
    check("notick_busy", if_a.tx_busy, 1'b1);
    stray = 0;
    repeat (600) begin
      @(negedge clk_sis);
      if (if_a.tx1 !== 1'b1) stray++;
    end
    check("notick_tx1_held", stray, 0);
    check("notick_busy_held", if_a.tx_busy, 1'b1);
    uart_en = 1'b1;
    capture_a(10, bits, busy_cyc, seen);
    check("notick_frame", bits, model_frame(8'h96));
    check("notick_busy_cyc", busy_cyc, model_busy(1'b0));
    repeat (300) @(negedge clk_sis);
    model_last_b = 8'h96;
    check("notick_rx_b", if_b.rx_data, model_last_b);
    check("notick_valid_b", vcnt_b - vb0, 1);

    // Random A->B frames against the frame model.
    for (int k = 0; k < 8; k++) begin
      d = 8'($urandom);
      two = 1'($urandom_range(0, 1));
      vb0 = vcnt_b; fb0 = fcnt_b;
      launch(1'b1, d, two, 1'b0, 8'h00, 1'b0);
      capture_a(two ? 11 : 10, bits, busy_cyc, seen);
      repeat (200 + $urandom_range(0, 40)) @(negedge clk_sis);
      model_last_b = d;
      check($sformatf("rnd%0d_frame", k), bits, model_frame(d));
      check($sformatf("rnd%0d_busy_cyc", k), busy_cyc, model_busy(two));
      check($sformatf("rnd%0d_rx_b", k), if_b.rx_data, model_last_b);
      check($sformatf("rnd%0d_valid_b", k), vcnt_b - vb0, 1);
      check($sformatf("rnd%0d_ferr_b", k), fcnt_b - fb0, 0);
    end

    // Random bit-banged frames into B, some with a low stop bit.
    for (int k = 0; k < 8; k++) begin
      logic stop_ok;
      d = 8'($urandom);
      stop_ok = (k == 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
      vb0 = vcnt_b; fb0 = fcnt_b;
      bang_frame(d, stop_ok, $urandom_range(0, BIT_CYC));
      if (stop_ok) model_last_b = d;
      check($sformatf("bb%0d_rx_b", k), if_b.rx_data, model_last_b);
      check($sformatf("bb%0d_valid_b", k), vcnt_b - vb0, stop_ok ? 1 : 0);
      check($sformatf("bb%0d_ferr_b", k), fcnt_b - fb0, stop_ok ? 0 : 1);
    end

    // Quarter-bit glitch: neither data nor error.
    vb0 = vcnt_b; fb0 = fcnt_b;
    bb_en = 1'b1; bb_val = 1'b0;
    repeat (BIT_CYC / 4) @(negedge clk_sis);
    bb_val = 1'b1;
    repeat (2000) @(negedge clk_sis);
    bb_en = 1'b0;
    check("glitch_valid_b", vcnt_b - vb0, 0);
    check("glitch_ferr_b", fcnt_b - fb0, 0);
    check("glitch_rx_b", if_b.rx_data, model_last_b);

    // Reset in the middle of a data bit.
    vb0 = vcnt_b; fb0 = fcnt_b;
    launch(1'b1, 8'h5A, 1'b0, 1'b0, 8'h00, 1'b0);
    repeat (BIT_CYC * 4 + 64) @(negedge clk_sis);
    rst = 1'b0;
    #1;
    check("midrst_tx1_a", if_a.tx1, 1'b1);
    check("midrst_busy_a", if_a.tx_busy, 1'b0);
    check("midrst_rx_b", if_b.rx_data, 8'h00);
    repeat (5) @(negedge clk_sis);
    rst = 1'b1;
    repeat (2000) @(negedge clk_sis);
    check("midrst_valid_b", vcnt_b - vb0, 0);
    check("midrst_ferr_b", fcnt_b - fb0, 0);
    check("midrst_tx1_after", if_a.tx1, 1'b1);
    check("midrst_rx_b_after", if_b.rx_data, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
